// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: NOP encoding, default reset PC and
// the instruction-fetch state encoding.
package mips_pkg;

  localparam logic [31:0] NOP_INSN         = 32'h0000_0000;
  localparam logic [29:0] DEFAULT_RESET_PC = 30'h0C00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/if_stage_ifid_reg.sv
// IF/ID pipeline register. Flush beats load, load beats consume; a
// consume with no reload empties the slot and presents a NOP.
module ifid_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        load,
  input  logic        consume,
  input  logic [29:0] load_pc,
  input  logic [31:0] load_ins,
  output logic        id_valid,
  output logic [29:0] id_pc,
  output logic [31:0] id_ins
);

  // Slot update with flush > load > consume priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid <= 1'b0;
      id_pc    <= '0;
      id_ins   <= NOP_INSN;
    end else if (flush) begin
      id_valid <= 1'b0;
      id_ins   <= NOP_INSN;
    end else if (load) begin
      id_valid <= 1'b1;
      id_pc    <= load_pc;
      id_ins   <= load_ins;
    end else if (consume) begin
      id_valid <= 1'b0;
      id_ins   <= NOP_INSN;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: word-addressed PC, single-outstanding
// request/valid fetch, one-entry hold buffer for a full IF/ID, and
// redirect handling that discards in-flight responses.
// Optional macro IF_STAGE_PERF_EN enables the fetch/flush counters.
module if_stage
  import mips_pkg::*;
#(
  parameter logic [29:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [29:0] redirect_pc,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [29:0] id_pc,
  output logic [31:0] id_ins,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_flush_cnt
);

  fetch_state_t state;
  logic [29:0]  pc;
  logic         drop;
  logic         hold_valid;
  logic [31:0]  hold_ins;

  logic         ifid_free;
  logic         ifid_load;
  logic [31:0]  ifid_load_ins;

  assign ifid_free = !id_valid || id_ready;
  assign imem_req  = (state == ISSUE);
  assign imem_addr = pc;

  // Decide whether IF/ID is reloaded this cycle and from which source.
  always_comb begin
    ifid_load     = 1'b0;
    ifid_load_ins = imem_rdata;
    if (!redirect && ifid_free) begin
      if (state == WAIT && imem_rvalid && !drop) begin
        ifid_load = 1'b1;
      end else if (state == HOLD && hold_valid) begin
        ifid_load     = 1'b1;
        ifid_load_ins = hold_ins;
      end
    end
  end

  // PC, fetch FSM, drop flag and hold buffer; redirect overrides all.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      state      <= IDLE;
      drop       <= 1'b0;
      hold_valid <= 1'b0;
      hold_ins   <= '0;
    end else if (redirect) begin
      pc         <= redirect_pc;
      hold_valid <= 1'b0;
      case (state)
        WAIT: begin
          if (imem_rvalid) begin
            drop  <= 1'b0;
            state <= ISSUE;
          end else begin
            drop  <= 1'b1;
          end
        end
        // The request already left with the old pc; its response must be dropped.
        ISSUE: begin
          drop  <= 1'b1;
          state <= WAIT;
        end
        default: state <= ISSUE;
      endcase
    end else begin
      case (state)
        IDLE:  state <= ISSUE;
        ISSUE: state <= WAIT;
        WAIT: begin
          if (imem_rvalid) begin
            if (drop) begin
              drop  <= 1'b0;
              state <= ISSUE;
            end else if (ifid_free) begin
              pc    <= pc + 30'd1;
              state <= ISSUE;
            end else begin
              hold_ins   <= imem_rdata;
              hold_valid <= 1'b1;
              state      <= HOLD;
            end
          end
        end
        HOLD: begin
          if (ifid_free && hold_valid) begin
            hold_valid <= 1'b0;
            pc         <= pc + 30'd1;
            state      <= ISSUE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  ifid_reg u_ifid_reg (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect),
    .load     (ifid_load),
    .consume  (id_valid && id_ready),
    .load_pc  (pc),
    .load_ins (ifid_load_ins),
    .id_valid (id_valid),
    .id_pc    (id_pc),
    .id_ins   (id_ins)
  );

`ifdef IF_STAGE_PERF_EN
  logic [31:0] fetch_cnt;
  logic [31:0] flush_cnt;

  // Delivered-instruction and redirect counters; a flushed slot is not delivered.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (redirect)
        flush_cnt <= flush_cnt + 32'd1;
      else if (id_valid && id_ready)
        fetch_cnt <= fetch_cnt + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt;
  assign perf_flush_cnt = flush_cnt;
`else
  assign perf_fetch_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus a randomized
// run scored against a transaction-level model of the fetch stream.
module tb_if_stage;

`ifdef IF_STAGE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [29:0] redirect_pc;
  logic        imem_req;
  logic [29:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [29:0] id_pc;
  logic [31:0] id_ins;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_flush_cnt;

  int checks = 0;
  int errors = 0;

  // memory model state
  logic        m_pend;
  int          m_cnt;
  int          m_lat;
  logic [29:0] m_addr;
  logic [29:0] r_addr;

  // per-cycle observations captured before the active edge
  logic        ev_req, ev_resp, ev_redirect, ev_ready;
  logic [29:0] ev_req_addr, ev_resp_addr, ev_target;
  logic [31:0] ev_resp_data;
  logic        o_id_valid;
  logic [29:0] o_id_pc;
  logic [31:0] o_id_ins;
  logic [31:0] o_fetch, o_flush;

  typedef struct packed {
    logic [29:0] pc;
    logic [31:0] ins;
  } slot_t;

  if_stage #(.RESET_PC(30'h0C00)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_ins         (id_ins),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_flush_cnt (perf_flush_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    if (a == 30'h0C00) return 32'h2001_0005;
    return {a[15:0], ~a[15:0]} ^ 32'h5A00_00A5;
  endfunction

  // One clock: record this cycle's view, pass the edge, then drive the
  // memory response for the next cycle.
  task automatic cycle();
    ev_req       = imem_req;
    ev_req_addr  = imem_addr;
    ev_resp      = imem_rvalid;
    ev_resp_addr = r_addr;
    ev_resp_data = imem_rdata;
    ev_redirect  = redirect;
    ev_target    = redirect_pc;
    ev_ready     = id_ready;
    o_id_valid   = id_valid;
    o_id_pc      = id_pc;
    o_id_ins     = id_ins;
    o_fetch      = perf_fetch_cnt;
    o_flush      = perf_flush_cnt;
    if (imem_req) begin
      m_pend = 1'b1;
      m_cnt  = m_lat;
      m_addr = imem_addr;
    end
    if (rst) m_pend = 1'b0;
    @(posedge clk);
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (m_pend) begin
      m_cnt = m_cnt - 1;
      if (m_cnt <= 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(m_addr);
        r_addr      = m_addr;
        m_pend      = 1'b0;
      end
    end
  endtask

  // Leaves the bench in the first cycle after rst deasserts.
  task automatic do_reset();
    rst      = 1'b1;
    redirect = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect = 1'b0; id_ready = 1'b0; m_lat = 1;
    cycle();
    cycle();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    checks++; if (imem_addr !== 30'h0C00) begin errors++; $display("FAIL reset_addr: got %h expected 0c00", imem_addr); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid: got %b expected 0", id_valid); end
    checks++; if (id_pc !== 30'h0) begin errors++; $display("FAIL reset_id_pc: got %h expected 0", id_pc); end
    checks++; if (id_ins !== 32'h0) begin errors++; $display("FAIL reset_id_ins: got %h expected 0", id_ins); end
    checks++; if (perf_fetch_cnt !== 32'h0 || perf_flush_cnt !== 32'h0) begin errors++; $display("FAIL reset_perf: got %h/%h expected 0/0", perf_fetch_cnt, perf_flush_cnt); end
  endtask

  task automatic test_first_fetch();
    m_lat = 1; id_ready = 1'b1;
    do_reset();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL ff_req_c1: got %b expected 0", imem_req); end
    cycle();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 30'h0C00) begin errors++; $display("FAIL ff_req_c2: got %b/%h expected 1/0c00", imem_req, imem_addr); end
    cycle();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL ff_valid_c3: got %b expected 0", id_valid); end
    cycle();
    checks++; if (id_valid !== 1'b1 || id_pc !== 30'h0C00 || id_ins !== 32'h2001_0005) begin errors++; $display("FAIL ff_ifid: got %b/%h/%h expected 1/0c00/20010005", id_valid, id_pc, id_ins); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 30'h0C01) begin errors++; $display("FAIL ff_next_req: got %b/%h expected 1/0c01", imem_req, imem_addr); end
  endtask

  task automatic test_hold();
    m_lat = 1; id_ready = 1'b0;
    do_reset();
    repeat (4) cycle();
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hold_req[%0d]: got %b expected 0", i, imem_req); end
      checks++; if (id_valid !== 1'b1 || id_pc !== 30'h0C00 || id_ins !== 32'h2001_0005) begin errors++; $display("FAIL hold_ifid[%0d]: got %b/%h/%h expected 1/0c00/20010005", i, id_valid, id_pc, id_ins); end
    end
    id_ready = 1'b1;
    cycle();
    checks++; if (id_valid !== 1'b1 || id_pc !== 30'h0C01 || id_ins !== mem_word(30'h0C01)) begin errors++; $display("FAIL hold_release: got %b/%h/%h expected 1/0c01/%h", id_valid, id_pc, id_ins, mem_word(30'h0C01)); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 30'h0C02) begin errors++; $display("FAIL hold_next_req: got %b/%h expected 1/0c02", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_wait();
    m_lat = 3; id_ready = 1'b1;
    do_reset();
    cycle();
    cycle();
    redirect = 1'b1; redirect_pc = 30'h0C40;
    cycle();
    redirect = 1'b0; m_lat = 1;
    for (int i = 0; i < 2; i++) begin
      checks++; if (id_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL rw_wait[%0d]: got valid %b req %b expected 0/0", i, id_valid, imem_req); end
      cycle();
    end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 30'h0C40 || id_valid !== 1'b0) begin errors++; $display("FAIL rw_target_req: got %b/%h valid %b expected 1/0c40 valid 0", imem_req, imem_addr, id_valid); end
    cycle();
    cycle();
    checks++; if (id_valid !== 1'b1 || id_pc !== 30'h0C40 || id_ins !== mem_word(30'h0C40)) begin errors++; $display("FAIL rw_target_ifid: got %b/%h/%h expected 1/0c40/%h", id_valid, id_pc, id_ins, mem_word(30'h0C40)); end
  endtask

  task automatic test_redirect_rvalid();
    m_lat = 1; id_ready = 1'b1;
    do_reset();
    cycle();
    cycle();
    id_ready = 1'b0;
    cycle();
    cycle();
    checks++; if (imem_rvalid !== 1'b1 || id_valid !== 1'b1) begin errors++; $display("FAIL rr_setup: got rvalid %b valid %b expected 1/1", imem_rvalid, id_valid); end
    id_ready = 1'b1; redirect = 1'b1; redirect_pc = 30'h1234;
    cycle();
    redirect = 1'b0;
    checks++; if (id_valid !== 1'b0 || id_ins !== 32'h0) begin errors++; $display("FAIL rr_flush: got %b/%h expected 0/00000000", id_valid, id_ins); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 30'h1234) begin errors++; $display("FAIL rr_req: got %b/%h expected 1/1234", imem_req, imem_addr); end
    checks++; if (perf_fetch_cnt !== (PERF ? 32'd0 : 32'd0) || perf_flush_cnt !== (PERF ? 32'd1 : 32'd0)) begin errors++; $display("FAIL rr_perf: got %0d/%0d expected 0/%0d", perf_fetch_cnt, perf_flush_cnt, PERF ? 1 : 0); end
    cycle();
    cycle();
    checks++; if (id_valid !== 1'b1 || id_pc !== 30'h1234 || id_ins !== mem_word(30'h1234)) begin errors++; $display("FAIL rr_target_ifid: got %b/%h/%h expected 1/1234/%h", id_valid, id_pc, id_ins, mem_word(30'h1234)); end
  endtask

  task automatic test_wrap();
    m_lat = 1; id_ready = 1'b1;
    do_reset();
    redirect = 1'b1; redirect_pc = 30'h3FFF_FFFF;
    cycle();
    redirect = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 30'h3FFF_FFFF) begin errors++; $display("FAIL wrap_req: got %b/%h expected 1/3fffffff", imem_req, imem_addr); end
    cycle();
    cycle();
    checks++; if (id_valid !== 1'b1 || id_pc !== 30'h3FFF_FFFF || id_ins !== mem_word(30'h3FFF_FFFF)) begin errors++; $display("FAIL wrap_ifid: got %b/%h/%h expected 1/3fffffff/%h", id_valid, id_pc, id_ins, mem_word(30'h3FFF_FFFF)); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 30'h0) begin errors++; $display("FAIL wrap_next: got %b/%h expected 1/0", imem_req, imem_addr); end
  endtask

  task automatic test_rst_mid();
    m_lat = 1; id_ready = 1'b1;
    do_reset();
    repeat (3) cycle();
    m_lat = 3;
    cycle();
    checks++; if (imem_req !== 1'b0 || imem_rvalid !== 1'b0) begin errors++; $display("FAIL rm_wait_setup: got req %b rvalid %b expected 0/0", imem_req, imem_rvalid); end
    rst = 1'b1;
    cycle();
    checks++; if (imem_req !== 1'b0 || imem_addr !== 30'h0C00) begin errors++; $display("FAIL rm_wait_req: got %b/%h expected 0/0c00", imem_req, imem_addr); end
    checks++; if (id_valid !== 1'b0 || id_pc !== 30'h0 || id_ins !== 32'h0) begin errors++; $display("FAIL rm_wait_ifid: got %b/%h/%h expected 0/0/0", id_valid, id_pc, id_ins); end
    checks++; if (perf_fetch_cnt !== 32'h0 || perf_flush_cnt !== 32'h0) begin errors++; $display("FAIL rm_wait_perf: got %h/%h expected 0/0", perf_fetch_cnt, perf_flush_cnt); end
    rst = 1'b0; m_lat = 1; id_ready = 1'b0;
    repeat (5) cycle();
    checks++; if (imem_req !== 1'b0 || id_valid !== 1'b1 || imem_rvalid !== 1'b0) begin errors++; $display("FAIL rm_hold_setup: got req %b valid %b rvalid %b expected 0/1/0", imem_req, id_valid, imem_rvalid); end
    rst = 1'b1;
    cycle();
    checks++; if (imem_req !== 1'b0 || imem_addr !== 30'h0C00) begin errors++; $display("FAIL rm_hold_req: got %b/%h expected 0/0c00", imem_req, imem_addr); end
    checks++; if (id_valid !== 1'b0 || id_pc !== 30'h0 || id_ins !== 32'h0) begin errors++; $display("FAIL rm_hold_ifid: got %b/%h/%h expected 0/0/0", id_valid, id_pc, id_ins); end
    checks++; if (perf_fetch_cnt !== 32'h0 || perf_flush_cnt !== 32'h0) begin errors++; $display("FAIL rm_hold_perf: got %h/%h expected 0/0", perf_fetch_cnt, perf_flush_cnt); end
    rst = 1'b0; id_ready = 1'b1;
    repeat (3) cycle();
    checks++; if (id_valid !== 1'b1 || id_pc !== 30'h0C00 || id_ins !== 32'h2001_0005) begin errors++; $display("FAIL rm_restart: got %b/%h/%h expected 1/0c00/20010005", id_valid, id_pc, id_ins); end
  endtask

  // Random traffic against a transaction model: the fetch address stream,
  // the in-order delivered stream and the counters.
  task automatic test_random();
    slot_t       q[$];
    slot_t       s;
    logic [29:0] exp_addr;
    logic        inflight, stale;
    int          exp_fetch, exp_flush, n_deliv;
    exp_addr = 30'h0C00; inflight = 1'b0; stale = 1'b0;
    exp_fetch = 0; exp_flush = 0; n_deliv = 0;
    m_lat = 1; id_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      id_ready = ($urandom_range(9) < 7);
      redirect = ($urandom_range(13) == 0);
      case ($urandom_range(3))
        0:       redirect_pc = 30'h3FFF_FFFE + 30'($urandom_range(1));
        1:       redirect_pc = 30'h0C00 + 30'($urandom_range(63));
        default: redirect_pc = 30'($urandom);
      endcase
      m_lat = 1 + $urandom_range(2);
      cycle();
      checks++; if (o_id_valid !== (q.size() != 0)) begin errors++; $display("FAIL rnd_valid@%0d: got %b expected %b", c, o_id_valid, q.size() != 0); end
      if (!o_id_valid) begin
        checks++; if (o_id_ins !== 32'h0) begin errors++; $display("FAIL rnd_nop@%0d: got %h expected 00000000", c, o_id_ins); end
      end
      checks++; if (o_fetch !== (PERF ? 32'(exp_fetch) : 32'd0) || o_flush !== (PERF ? 32'(exp_flush) : 32'd0)) begin errors++; $display("FAIL rnd_perf@%0d: got %0d/%0d expected %0d/%0d", c, o_fetch, o_flush, PERF ? exp_fetch : 0, PERF ? exp_flush : 0); end
      if (o_id_valid && ev_ready && !ev_redirect && q.size() != 0) begin
        s = q.pop_front();
        checks++; if (o_id_pc !== s.pc || o_id_ins !== s.ins) begin errors++; $display("FAIL rnd_deliver@%0d: got %h/%h expected %h/%h", c, o_id_pc, o_id_ins, s.pc, s.ins); end
        exp_fetch++; n_deliv++;
      end
      if (ev_resp) begin
        if (!stale && !ev_redirect) begin
          q.push_back('{pc: ev_resp_addr, ins: ev_resp_data});
          exp_addr = ev_resp_addr + 30'd1;
        end
        inflight = 1'b0;
      end
      if (ev_req) begin
        checks++; if (inflight) begin errors++; $display("FAIL rnd_overlap@%0d: got request with one outstanding expected none", c); end
        checks++; if (ev_req_addr !== exp_addr) begin errors++; $display("FAIL rnd_addr@%0d: got %h expected %h", c, ev_req_addr, exp_addr); end
        inflight = 1'b1; stale = 1'b0;
      end
      if (ev_redirect) begin
        q.delete();
        exp_addr = ev_target;
        stale = 1'b1;
        exp_flush++;
      end
    end
    redirect = 1'b0;
    checks++; if (n_deliv < 100) begin errors++; $display("FAIL rnd_progress: got %0d deliveries expected at least 100", n_deliv); end
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; m_pend = 1'b0; m_cnt = 0; m_lat = 1;
    m_addr = '0; r_addr = '0;
    @(negedge clk);
    test_reset();
    test_first_fetch();
    test_hold();
    test_redirect_wait();
    test_redirect_rvalid();
    test_wrap();
    test_rst_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
